// File: rtl/timing_sequencer.sv
// T-state ring sequencer for the CPU control unit.
// Free-run / single-step modes, HALT freeze, retired-instruction counter.
module timing_sequencer #(
   parameter int         COUNT_W = 8,
   parameter logic [3:0] HALT_OP = 4'b1111
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         opcode,
   input  logic               run,
   input  logic               step,
   output logic               t0,
   output logic               t1,
   output logic               t2,
   output logic               t3,
   output logic               t4,
   output logic               t5,
   output logic [2:0]         t_idx,
   output logic               halted,
   output logic               busy,
   output logic               instr_done,
   output logic [COUNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_STEP,
      S_HALT
   } state_e;

   state_e             st_q, st_d;
   logic [5:0]         ring_q, ring_d;
   logic [2:0]         idx_q, idx_d;
   logic               step_q;
   logic               halted_q, halted_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;

   logic               is_long;
   logic               is_halt;
   logic               wraps;

   assign is_long = (opcode == 4'b0000) ||
                    (opcode == 4'b0011) ||
                    (opcode == 4'b0100);
   assign is_halt = (opcode == HALT_OP);
   assign wraps   = ring_q[5] |
                    (ring_q[3] & ~is_long & ~is_halt);

   // Next-state: mode transitions, ring advance and retire bookkeeping
   always_comb begin
      st_d   = st_q;
      ring_d = ring_q;
      idx_d  = idx_q;
      done_d = 1'b0;
      cnt_d  = cnt_q;
      unique case (st_q)
         S_IDLE: begin
            ring_d = 6'b000001;
            idx_d  = 3'd0;
            if (run)
               st_d = S_RUN;
            else if (step & ~step_q)
               st_d = S_STEP;
         end
         S_RUN, S_STEP: begin
            if (ring_q[3] && is_halt) begin
               st_d = S_HALT;
            end else if (wraps) begin
               ring_d = 6'b000001;
               idx_d  = 3'd0;
               done_d = 1'b1;
               cnt_d  = cnt_q + 1'b1;
               st_d   = run ? S_RUN : S_IDLE;
            end else begin
               ring_d = {ring_q[4:0], 1'b0};
               idx_d  = idx_q + 3'd1;
            end
         end
         S_HALT: begin
            st_d = S_HALT;
         end
      endcase
      halted_d = (st_d == S_HALT);
      busy_d   = (st_d == S_RUN) || (st_d == S_STEP);
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         st_q     <= S_IDLE;
         ring_q   <= 6'b000001;
         idx_q    <= 3'd0;
         step_q   <= 1'b0;
         halted_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         st_q     <= st_d;
         ring_q   <= ring_d;
         idx_q    <= idx_d;
         step_q   <= step;
         halted_q <= halted_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
      end
   end

   assign t0          = ring_q[0];
   assign t1          = ring_q[1];
   assign t2          = ring_q[2];
   assign t3          = ring_q[3];
   assign t4          = ring_q[4];
   assign t5          = ring_q[5];
   assign t_idx       = idx_q;
   assign halted      = halted_q;
   assign busy        = busy_q;
   assign instr_done  = done_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// Bench for timing_sequencer: directed scenarios plus random traffic,
// every cycle compared against an instruction-level reference model.
module tb_timing_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] opcode;
   logic       run;
   logic       step;
   logic       t0, t1, t2, t3, t4, t5;
   logic [2:0] t_idx;
   logic       halted, busy, instr_done;
   logic [7:0] instr_count;

   int checks   = 0;
   int failures = 0;

   // model: mode 0 idle, 1 run, 2 step, 3 halt
   int m_mode;
   int m_t;
   int m_cnt;
   bit m_done;
   bit m_prev_step;
   int halt_cycles;
   int done_seen;

   always #5 clk = ~clk;

   timing_sequencer #(
      .COUNT_W(8),
      .HALT_OP(4'b1111)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .run        (run),
      .step       (step),
      .t0         (t0),
      .t1         (t1),
      .t2         (t2),
      .t3         (t3),
      .t4         (t4),
      .t5         (t5),
      .t_idx      (t_idx),
      .halted     (halted),
      .busy       (busy),
      .instr_done (instr_done),
      .instr_count(instr_count)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h @%0t",
                tag, obs, exp, $time);
      end
   endtask

   function automatic int instr_len(logic [3:0] op);
      if (op == 4'd0 || op == 4'd3 || op == 4'd4)
         return 6;
      return 4;
   endfunction

   task automatic model_edge();
      m_done = 1'b0;
      if (!reset) begin
         m_mode      = 0;
         m_t         = 0;
         m_cnt       = 0;
         m_prev_step = 1'b0;
         return;
      end
      if (m_mode == 0) begin
         if (run)
            m_mode = 1;
         else if (step && !m_prev_step)
            m_mode = 2;
      end else if (m_mode == 1 || m_mode == 2) begin
         if (m_t == 3 && opcode == 4'hF) begin
            m_mode = 3;
         end else if (m_t == 3 && instr_len(opcode) == 4
                      || m_t == 5) begin
            m_t    = 0;
            m_done = 1'b1;
            m_cnt  = (m_cnt + 1) % 256;
            m_mode = run ? 1 : 0;
         end else begin
            m_t = m_t + 1;
         end
      end
      m_prev_step = step;
   endtask

   task automatic cyc();
      logic [5:0] exp_ring;
      model_edge();
      @(posedge clk);
      #1;
      exp_ring = 6'b000001 << m_t;
      chk("ring", {26'd0, t5, t4, t3, t2, t1, t0}, {26'd0, exp_ring});
      chk("t_idx", {29'd0, t_idx}, m_t);
      chk("halted", {31'd0, halted}, {31'd0, m_mode == 3});
      chk("busy", {31'd0, busy},
          {31'd0, (m_mode == 1 || m_mode == 2)});
      chk("instr_done", {31'd0, instr_done}, {31'd0, m_done});
      chk("instr_count", {24'd0, instr_count}, m_cnt);
      if (instr_done)
         done_seen++;
      if (m_mode == 3)
         halt_cycles++;
      else
         halt_cycles = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
   endtask

   task automatic wait_t(int idx, int budget);
      int n = 0;
      while (m_t != idx && n < budget) begin
         cyc();
         n++;
      end
      chk("wait_t_timeout", {31'd0, m_t == idx}, 32'd1);
   endtask

   initial begin
      logic [3:0] ops [7];
      ops[0] = 4'h0; ops[1] = 4'h3; ops[2] = 4'h4;
      ops[3] = 4'hE; ops[4] = 4'h1; ops[5] = 4'h7;
      ops[6] = 4'hF;
      reset  = 1'b0;
      run    = 1'b0;
      step   = 1'b0;
      opcode = 4'h0;
      m_mode = 0; m_t = 0; m_cnt = 0;
      m_done = 0; m_prev_step = 0;
      halt_cycles = 0;
      done_seen   = 0;

      // reset state
      do_reset();
      cyc();

      // mixed-length program
      run    = 1'b1;
      opcode = 4'h0;
      repeat (20) cyc();
      wait_t(2, 10);
      opcode = 4'hE;
      repeat (14) cyc();

      // HALT freeze, inputs ignored, reset exits
      opcode = 4'hF;
      repeat (10) cyc();
      repeat (50) begin
         run  = 1'($urandom);
         step = 1'($urandom);
         cyc();
      end
      chk("halt_held", {31'd0, halted & t3}, 32'd1);
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      chk("halt_reset_cnt", {24'd0, instr_count}, 32'd0);
      chk("halt_reset_t0", {31'd0, t0}, 32'd1);

      // single step, two passes
      run    = 1'b0;
      step   = 1'b0;
      opcode = 4'h3;
      cyc();
      step = 1'b1;
      repeat (20) cyc();
      step = 1'b0;
      repeat (5) cyc();
      step = 1'b1;
      repeat (20) cyc();
      step = 1'b0;
      cyc();
      chk("step_count", {24'd0, instr_count}, 32'd2);

      // run dropped mid-instruction
      run    = 1'b1;
      opcode = 4'h4;
      repeat (3) cyc();
      wait_t(2, 10);
      run = 1'b0;
      repeat (10) cyc();
      chk("drop_idle", {31'd0, busy}, 32'd0);

      // reset while at t4
      run = 1'b1;
      wait_t(4, 20);
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      chk("rst_t4_idx", {29'd0, t_idx}, 32'd0);
      chk("rst_t4_cnt", {24'd0, instr_count}, 32'd0);
      run = 1'b0;
      cyc();

      // counter wrap after 256 short instructions
      do_reset();
      run       = 1'b1;
      opcode    = 4'hE;
      done_seen = 0;
      for (int i = 0; i < 1200 && done_seen < 256; i++)
         cyc();
      chk("wrap_pulses", done_seen, 32'd256);
      chk("wrap_count", {24'd0, instr_count}, 32'd0);

      // step edges in RUN are not queued
      opcode = 4'h0;
      repeat (3) begin
         step = 1'b1;
         cyc();
         step = 1'b0;
         cyc();
      end
      run = 1'b0;
      repeat (12) cyc();
      chk("no_queue", {31'd0, busy}, 32'd0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0)
            run = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 3) == 0)
            step = ~step;
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 39) == 0)
               opcode = ops[6];
            else
               opcode = ops[$urandom_range(0, 5)];
         end
         reset = !(halt_cycles > 30 || $urandom_range(0, 299) == 0);
         cyc();
      end
      reset = 1'b1;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
